// File: rtl/dtree_seq_engine_if.sv
// Sample-in / result-out handshake bundle for the decision-tree engine.
// The master drives samples and accepts results; the slave is the engine.
interface dtree_seq_engine_if #(
    parameter int N_FEAT  = 18,
    parameter int FEAT_W  = 8,
    parameter int CLASS_W = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic                     out_err;

    modport master (
        output in_valid, in_feat, out_ready,
        input  in_ready, out_valid, out_class, out_err
    );

    modport slave (
        input  in_valid, in_feat, out_ready,
        output in_ready, out_valid, out_class, out_err
    );
endinterface

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: walks a programmable node memory,
// one tree level per clock, from root node 0 to a leaf.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | in_ready=1, node memory writable, waiting for a sample
//  WALK   | evaluating one node per cycle until leaf or abort
//  DONE   | result held on out_class/out_err with out_valid=1
module dtree_seq_engine #(
    parameter int N_FEAT     = 18,
    parameter int FEAT_W     = 8,
    parameter int NODE_DEPTH = 64,
    parameter int MAX_LEVELS = 16,
    parameter int CLASS_W    = 2,
    parameter int IDX_W      = $clog2(N_FEAT),
    parameter int SH_W       = $clog2(FEAT_W),
    parameter int AW         = $clog2(NODE_DEPTH),
    parameter int NODE_W     = 1 + IDX_W + SH_W + FEAT_W + 2*AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    dtree_seq_engine_if.slave bus
);
    localparam int LVL_W = (MAX_LEVELS > 1) ? $clog2(MAX_LEVELS) : 1;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(MAX_LEVELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t                   state_q;
    logic [NODE_W-1:0]        mem [NODE_DEPTH];
    logic [N_FEAT*FEAT_W-1:0] feat_q;
    logic [AW-1:0]            node_q;
    logic [LVL_W-1:0]         level_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     out_err_q;
    logic [CLASS_W-1:0]       out_class_q;

    logic [NODE_W-1:0] n_word;
    logic              n_leaf;
    logic [IDX_W-1:0]  n_feat;
    logic [SH_W-1:0]   n_shift;
    logic [FEAT_W-1:0] n_thr;
    logic [AW-1:0]     n_left;
    logic [AW-1:0]     n_right;
    logic [FEAT_W-1:0] x_sel;
    logic              feat_ok;
    logic              cond;
    logic [AW-1:0]     node_d;

    assign n_word  = mem[node_q];
    assign n_leaf  = n_word[NODE_W-1];
    assign n_feat  = n_word[NODE_W-2 -: IDX_W];
    assign n_shift = n_word[NODE_W-2-IDX_W -: SH_W];
    assign n_thr   = n_word[2*AW +: FEAT_W];
    assign n_left  = n_word[AW +: AW];
    assign n_right = n_word[AW-1:0];

    // Feature index field is wider than N_FEAT needs; out-of-range indices abort the walk.
    always_comb begin
        x_sel   = '0;
        feat_ok = 1'b0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (n_feat == IDX_W'(i)) begin
                x_sel   = feat_q[i*FEAT_W +: FEAT_W];
                feat_ok = 1'b1;
            end
        end
    end

    assign cond   = (x_sel >> n_shift) <= n_thr;
    assign node_d = cond ? n_left : n_right;

    // Node memory deliberately has no reset so the loaded tree survives rst.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            node_q      <= '0;
            level_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        feat_q     <= bus.in_feat;
                        node_q     <= '0;
                        level_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (n_leaf) begin
                        out_class_q <= n_word[CLASS_W-1:0];
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (!feat_ok || level_q == LVL_LAST) begin
                        out_class_q <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        node_q  <= node_d;
                        level_q <= level_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed bench for dtree_seq_engine: small hand-built trees with
// hand-computed classes, latencies and handshake behaviour.
module tb_dtree_seq_engine;
    localparam int N_FEAT = 18;
    localparam int FEAT_W = 8;
    localparam int NODE_W = 29;
    localparam int XW     = N_FEAT * FEAT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [5:0]        cfg_addr;
    logic [NODE_W-1:0] cfg_data;
    int                n_checks = 0;
    int                n_errors = 0;

    dtree_seq_engine_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(2)) bus ();

    dtree_seq_engine dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] mk_node(input int feat, input int sh, input int thr,
                                                 input int left, input int right);
        return {1'b0, 5'(feat), 3'(sh), 8'(thr), 6'(left), 6'(right)};
    endfunction

    function automatic logic [NODE_W-1:0] mk_leaf(input int cls);
        return {1'b1, 26'd0, 2'(cls)};
    endfunction

    function automatic logic [XW-1:0] mkx(input int idx, input logic [7:0] v);
        logic [XW-1:0] x;
        x = '0;
        x[idx*FEAT_W +: FEAT_W] = v;
        return x;
    endfunction

    task automatic cfg_write(input int addr, input logic [NODE_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_addr = 6'(addr);
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic load_tree(input logic [NODE_W-1:0] root);
        cfg_write(0, root);
        cfg_write(1, mk_leaf(1));
        cfg_write(2, mk_leaf(3));
    endtask

    // Accept a sample, then count cycles until out_valid (bounded).
    task automatic submit_wait(input string tag, input logic [XW-1:0] x, input int lat,
                               input int cls, input logic err);
        int n;
        bus.in_valid = 1'b1;
        bus.in_feat  = x;
        tick();
        bus.in_valid = 1'b0;
        bus.in_feat  = '1;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_class"}, 32'(bus.out_class), 32'(cls));
        check({tag, "_err"}, 32'(bus.out_err), 32'(err));
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic classify(input string tag, input logic [XW-1:0] x, input int lat,
                            input int cls, input logic err);
        submit_wait(tag, x, lat, cls, err);
        handoff(tag);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        bus.in_valid  = 1'b0;
        bus.in_feat   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_class", 32'(bus.out_class), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);

        // Root: (X7 >> 5) <= 5 ? leaf1 : leaf3
        load_tree(mk_node(7, 5, 5, 1, 2));
        classify("a0", mkx(7, 8'hA0), 2, 1, 1'b0);
        classify("c0", mkx(7, 8'hC0), 2, 3, 1'b0);

        // Stall in DONE with in_valid pulses and changing in_feat.
        submit_wait("hold", mkx(7, 8'hA0), 2, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_feat  = mkx(7, 8'hFF);
            tick();
            check("hold_vld", 32'(bus.out_valid), 32'd1);
            check("hold_class", 32'(bus.out_class), 32'd1);
            check("hold_err", 32'(bus.out_err), 32'd0);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        handoff("hold");

        // Shift / threshold boundaries on feature 0.
        cfg_write(0, mk_node(0, 0, 255, 1, 2));
        classify("sh0_ff", mkx(0, 8'hFF), 2, 1, 1'b0);
        cfg_write(0, mk_node(0, 7, 0, 1, 2));
        classify("sh7_7f", mkx(0, 8'h7F), 2, 1, 1'b0);
        classify("sh7_80", mkx(0, 8'h80), 2, 3, 1'b0);
        cfg_write(0, mk_node(0, 4, 2, 1, 2));
        classify("sh4_2f", mkx(0, 8'h2F), 2, 1, 1'b0);
        classify("sh4_30", mkx(0, 8'h30), 2, 3, 1'b0);

        // Abort paths: bad feature index, then a self-loop hitting the level limit.
        cfg_write(0, mk_node(20, 0, 0, 1, 2));
        classify("badfeat", mkx(0, 8'h00), 1, 0, 1'b1);
        cfg_write(0, mk_node(0, 0, 255, 0, 0));
        classify("overflow", mkx(0, 8'h10), 16, 0, 1'b1);

        // Write to node1 while walking must be dropped.
        cfg_write(0, mk_node(7, 5, 5, 1, 2));
        bus.in_valid = 1'b1;
        bus.in_feat  = mkx(7, 8'hA0);
        tick();
        bus.in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 6'd1;
        cfg_data = mk_leaf(2);
        tick();
        tick();
        cfg_we = 1'b0;
        check("wewalk_vld", 32'(bus.out_valid), 32'd1);
        check("wewalk_class", 32'(bus.out_class), 32'd1);
        handoff("wewalk");

        cfg_write(1, mk_leaf(2));
        classify("weidle", mkx(7, 8'hA0), 2, 2, 1'b0);

        // Write and accept in the same cycle: walk sees the new word.
        cfg_we       = 1'b1;
        cfg_addr     = 6'd1;
        cfg_data     = mk_leaf(1);
        bus.in_valid = 1'b1;
        bus.in_feat  = mkx(7, 8'h00);
        tick();
        cfg_we       = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("samecyc_vld", 32'(bus.out_valid), 32'd1);
        check("samecyc_class", 32'(bus.out_class), 32'd1);
        handoff("samecyc");

        // Reset mid-walk aborts the sample but keeps the tree.
        cfg_write(1, mk_leaf(2));
        bus.in_valid = 1'b1;
        bus.in_feat  = mkx(7, 8'hA0);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstwalk_in_ready", 32'(bus.in_ready), 32'd1);
        check("rstwalk_vld", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        check("rstwalk_vld_later", 32'(bus.out_valid), 32'd0);
        classify("resubmit", mkx(7, 8'hA0), 2, 2, 1'b0);
        classify("resubmit_r", mkx(7, 8'hC0), 2, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
